// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl
//   Ramps a PWM duty value from its current level toward a target in fixed
//   steps, one step every (rate+1) PWM periods, then holds the final value.
//   A free-running phase counter mirrors the PWM's internal counter so that
//   duty updates land exactly on PWM period boundaries.
//
// Parameters
//   R : duty / PWM counter width (PWM period = 2^R clk cycles)
//   P : rate prescaler width
//
// Ports
//   clk     : clock, all state updates on the rising edge
//   reset_n : synchronous active-low reset
//   start   : one-cycle request to begin a ramp (ignored while ramping)
//   abort   : one-cycle request to stop and return to idle (beats start)
//   target  : final duty value, sampled on accepted start
//   step    : duty change per update (0 treated as 1), sampled on accepted start
//   rate    : PWM periods per update minus 1, sampled on accepted start
//   duty    : registered duty value to the PWM
//   pwm_en  : registered PWM enable
//   busy    : high while ramping
//   done    : one-cycle pulse on the first cycle of HOLD
module pwm_ramp_ctrl #(
  parameter int unsigned R = 8,
  parameter int unsigned P = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         abort,
  input  logic [R-1:0] target,
  input  logic [R-1:0] step,
  input  logic [P-1:0] rate,
  output logic [R-1:0] duty,
  output logic         pwm_en,
  output logic         busy,
  output logic         done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RAMP = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]   state;
  logic [R-1:0] phase;
  logic [R-1:0] tgt;
  logic [R-1:0] stp;
  logic [P-1:0] rt;
  logic [P-1:0] presc;

  logic         period_end;
  logic         start_ok;
  logic [R:0]   sum;
  logic [R:0]   diff;
  logic [R-1:0] next_duty;

  assign period_end = pwm_en && (phase == '1);
  assign start_ok   = start && (state != S_RAMP);

  // Step computed one bit wider so carry/borrow reveals overshoot; the result
  // is clamped to the target so the ramp never passes it or wraps.
  always_comb begin
    sum       = {1'b0, duty} + {1'b0, stp};
    diff      = {1'b0, duty} - {1'b0, stp};
    next_duty = duty;
    if (tgt > duty) begin
      next_duty = (sum >= {1'b0, tgt}) ? tgt : sum[R-1:0];
    end else begin
      next_duty = (diff[R] || (diff[R-1:0] <= tgt)) ? tgt : diff[R-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      duty   <= '0;
      pwm_en <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      phase  <= '0;
      presc  <= '0;
      tgt    <= '0;
      stp    <= '0;
      rt     <= '0;
    end else begin
      done <= 1'b0;

      // Phase tracks the PWM counter; it is never cleared outside reset so
      // a new ramp stays aligned with the running PWM period.
      if (pwm_en) begin
        phase <= phase + R'(1);
      end

      if (abort) begin
        state  <= S_IDLE;
        duty   <= '0;
        pwm_en <= 1'b0;
        busy   <= 1'b0;
        presc  <= '0;
      end else if (start_ok) begin
        tgt    <= target;
        stp    <= (step == '0) ? R'(1) : step;
        rt     <= rate;
        presc  <= '0;
        pwm_en <= 1'b1;
        if (target == duty) begin
          state <= S_HOLD;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          state <= S_RAMP;
          busy  <= 1'b1;
        end
      end else if ((state == S_RAMP) && period_end) begin
        if (presc != rt) begin
          presc <= presc + P'(1);
        end else begin
          presc <= '0;
          duty  <= next_duty;
          if (next_duty == tgt) begin
            state <= S_HOLD;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Testbench for pwm_ramp_ctrl (R = 4, P = 4, PWM period 16 cycles).
// Stimulus pushes hand-computed expected output snapshots tagged with the
// clock edge number at which they must appear; a monitor samples on the
// falling edge, compares scheduled snapshots and flags any output change
// that was not scheduled.
module tb_pwm_ramp_ctrl;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic       abort;
  logic [3:0] target;
  logic [3:0] step;
  logic [3:0] rate;
  logic [3:0] duty;
  logic       pwm_en;
  logic       busy;
  logic       done;

  pwm_ramp_ctrl #(.R(4), .P(4)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .abort  (abort),
    .target (target),
    .step   (step),
    .rate   (rate),
    .duty   (duty),
    .pwm_en (pwm_en),
    .busy   (busy),
    .done   (done)
  );

  typedef struct {
    int         cyc;
    logic [3:0] duty;
    logic       en;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t q[$];
  int   cyc      = 0;
  int   tests    = 0;
  int   failures = 0;
  bit   finished = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic [3:0] d, input logic e,
                      input logic b, input logic dn);
    exp_t x;
    x.cyc = c; x.duty = d; x.en = e; x.busy = b; x.done = dn;
    q.push_back(x);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic s, input logic a, input logic [3:0] t,
                       input logic [3:0] st, input logic [3:0] r);
    start = s; abort = a; target = t; step = st; rate = r;
  endtask

  // Monitor
  logic [6:0] cur;
  logic [6:0] prev = '0;
  exp_t       e;

  always @(negedge clk) begin
    if (cyc >= 1 && !finished) begin
      cur = {duty, pwm_en, busy, done};
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        tests++;
        failures++;
        $display("FAIL missed_check@%0d: no sample taken, expected duty=%0d en=%b busy=%b done=%b",
                 e.cyc, e.duty, e.en, e.busy, e.done);
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        tests++;
        if (cur !== {e.duty, e.en, e.busy, e.done}) begin
          failures++;
          $display("FAIL check@%0d: got duty=%0d en=%b busy=%b done=%b, expected duty=%0d en=%b busy=%b done=%b",
                   cyc, duty, pwm_en, busy, done, e.duty, e.en, e.busy, e.done);
        end
      end else if (cur !== prev) begin
        tests++;
        failures++;
        $display("FAIL unexpected_change@%0d: got duty=%0d en=%b busy=%b done=%b, expected unchanged duty=%0d en=%b busy=%b done=%b",
                 cyc, duty, pwm_en, busy, done, prev[6:3], prev[2], prev[1], prev[0]);
      end
      prev = cur;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with start asserted
    reset_n = 1'b0;
    drive(1'b1, 1'b0, 4'd9, 4'd4, 4'd0);
    push(2, 4'd0, 1'b0, 1'b0, 1'b0);
    wait_cyc(4);
    reset_n = 1'b1;
    drive(1'b0, 1'b0, 4'd9, 4'd4, 4'd0);
    push(8, 4'd0, 1'b0, 1'b0, 1'b0);

    // Ramp up 0 -> 9, step 4, rate 0 (phase 0 at edge 11)
    wait_cyc(10);
    push(11, 4'd0, 1'b1, 1'b1, 1'b0);
    push(27, 4'd4, 1'b1, 1'b1, 1'b0);
    push(43, 4'd8, 1'b1, 1'b1, 1'b0);
    push(59, 4'd9, 1'b1, 1'b0, 1'b1);
    push(60, 4'd9, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 4'd9, 4'd4, 4'd0);
    wait_cyc(11);
    drive(1'b0, 1'b0, 4'd9, 4'd4, 4'd0);

    // Ramp down 9 -> 2, step 3, rate 2; period ends stay on edges = 11 mod 16
    wait_cyc(65);
    push(66, 4'd9, 1'b1, 1'b1, 1'b0);
    push(107, 4'd6, 1'b1, 1'b1, 1'b0);
    push(155, 4'd3, 1'b1, 1'b1, 1'b0);
    push(203, 4'd2, 1'b1, 1'b0, 1'b1);
    push(204, 4'd2, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 4'd2, 4'd3, 4'd2);
    wait_cyc(66);
    drive(1'b0, 1'b0, 4'd2, 4'd3, 4'd2);

    // Mid-ramp start + abort together: abort wins
    wait_cyc(210);
    push(211, 4'd2, 1'b1, 1'b1, 1'b0);
    push(219, 4'd7, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 4'd12, 4'd5, 4'd0);
    wait_cyc(211);
    drive(1'b0, 1'b0, 4'd12, 4'd5, 4'd0);
    wait_cyc(222);
    push(223, 4'd0, 1'b0, 1'b0, 1'b0);
    push(240, 4'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 4'd5, 4'd1, 4'd0);
    wait_cyc(223);
    drive(1'b0, 1'b0, 4'd5, 4'd1, 4'd0);

    // step = 0 treated as 1; start during RAMP ignored (phase 4 held in IDLE)
    wait_cyc(250);
    push(251, 4'd0, 1'b1, 1'b1, 1'b0);
    push(263, 4'd1, 1'b1, 1'b1, 1'b0);
    push(279, 4'd2, 1'b1, 1'b0, 1'b1);
    push(280, 4'd2, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 4'd2, 4'd0, 4'd0);
    wait_cyc(251);
    drive(1'b0, 1'b0, 4'd2, 4'd0, 4'd0);
    wait_cyc(265);
    drive(1'b1, 1'b0, 4'd15, 4'd7, 4'd0);
    wait_cyc(266);
    drive(1'b0, 1'b0, 4'd15, 4'd7, 4'd0);

    // target equal to current duty: straight to HOLD with done, no busy
    wait_cyc(290);
    push(291, 4'd2, 1'b1, 1'b0, 1'b1);
    push(292, 4'd2, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 4'd2, 4'd1, 4'd0);
    wait_cyc(291);
    drive(1'b0, 1'b0, 4'd2, 4'd1, 4'd0);
    wait_cyc(300);
    push(301, 4'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 4'd0, 4'd1, 4'd0);
    wait_cyc(301);
    drive(1'b0, 1'b0, 4'd0, 4'd1, 4'd0);
    wait_cyc(310);
    push(311, 4'd0, 1'b1, 1'b0, 1'b1);
    push(312, 4'd0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 4'd0, 4'd1, 4'd0);
    wait_cyc(311);
    drive(1'b0, 1'b0, 4'd0, 4'd1, 4'd0);

    // Reset mid-ramp overrides start and abort; phase restarts from 0
    wait_cyc(320);
    push(321, 4'd0, 1'b1, 1'b1, 1'b0);
    push(337, 4'd1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 4'd15, 4'd1, 4'd0);
    wait_cyc(321);
    drive(1'b0, 1'b0, 4'd15, 4'd1, 4'd0);
    wait_cyc(340);
    push(341, 4'd0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    drive(1'b1, 1'b1, 4'd15, 4'd1, 4'd0);
    wait_cyc(343);
    reset_n = 1'b1;
    drive(1'b0, 1'b0, 4'd15, 4'd1, 4'd0);
    wait_cyc(350);
    push(351, 4'd0, 1'b1, 1'b1, 1'b0);
    push(367, 4'd3, 1'b1, 1'b0, 1'b1);
    push(368, 4'd3, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 4'd3, 4'd3, 4'd0);
    wait_cyc(351);
    drive(1'b0, 1'b0, 4'd3, 4'd3, 4'd0);

    wait_cyc(380);
    @(negedge clk);
    #1;
    finished = 1;
    while (q.size() > 0) begin
      e = q.pop_front();
      tests++;
      failures++;
      $display("FAIL unchecked@%0d: never sampled, expected duty=%0d en=%b busy=%b done=%b",
               e.cyc, e.duty, e.en, e.busy, e.done);
    end
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
